vga_fb_arbiter: RTL and testbench
=================================

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter: FB_W, default 160, framebuffer width in pixels (display scale 4:1 horizontal).
REQ-002 Parameter: FB_H, default 120, framebuffer height in pixels (display scale 4:1 vertical).
REQ-003 Parameter: ADDR_W, default 15, framebuffer address width.
REQ-004 Parameter: PIX_W, default 3, pixel width (RGB 1-1-1).
REQ-005 Port: clk, input, 1, system clock; shared with the VGA timing driver.
REQ-006 Port: rst, input, 1, synchronous, active-high reset.
REQ-007 Port: posX, input, 11, next horizontal pixel position from the VGA timing driver.
REQ-008 Port: posY, input, 11, next vertical pixel position from the VGA timing driver.
REQ-009 Port: pixel_to_vga, output, PIX_W, pixel value toward the VGA driver pixel input.
REQ-010 Port: mem_addr/mem_we/mem_wdata, output, ADDR_W/1/PIX_W, single-port framebuffer RAM control; RAM read latency is 1 cycle.
REQ-011 Port: mem_rdata, input, PIX_W, RAM read data.
REQ-012 Port: wN_valid/wN_addr/wN_data, input, 1/ADDR_W/PIX_W, write requester N (N = 0, 1).
REQ-013 Port: wN_ready, output, 1, write requester N accept.
REQ-014 Port: wr_vblank_only, input, 1; when high, writes are granted only while posY >= 480.
REQ-015 Port: frame_tick, output, 1, one-cycle pulse per frame.
REQ-016 Port: err_oob, output, 1, sticky out-of-range write flag.
REQ-017 Port: wr_count_last, output, 16, writes accepted during the previous frame.

Function
REQ-018 Display read slot: disp = (posX < 640) && (posY < 480) && (posX[1:0] == 0).
REQ-019 In a display slot: mem_we = 0 and mem_addr = (posY >> 2) * FB_W + (posX >> 2), computed without truncation before narrowing to ADDR_W.
REQ-020 The cycle after a display slot, pix_reg loads mem_rdata; otherwise pix_reg holds its value.
REQ-021 pixel_to_vga = pix_reg; display fetch-to-output latency is 1 cycle after the slot cycle.
REQ-022 Display slots have absolute priority; no write is granted in a display slot.
REQ-023 Write slot: any cycle that is not a display slot and that meets the condition (wr_vblank_only == 0 || posY >= 480).
REQ-024 In a write slot, if exactly one wN_valid is high, that requester is granted.
REQ-025 In a write slot, if both wN_valid are high, the requester other than last_grant is granted (round-robin).
REQ-026 last_grant updates only on a transfer.
REQ-027 wN_ready is combinational and is high only for the granted requester in a write slot.
REQ-028 A transfer is wN_valid && wN_ready.
REQ-029 Requesters SHALL hold addr and data stable while valid is high and ready is low.
REQ-030 On a transfer with wN_addr < FB_W * FB_H: mem_we = 1, mem_addr = wN_addr, mem_wdata = wN_data in the same cycle.
REQ-031 On a transfer with wN_addr >= FB_W * FB_H: the transfer completes (ready high), mem_we = 0, and err_oob sets and stays set until rst.
REQ-032 When no transfer and no display slot occur: mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-033 frame_tick pulses for one cycle in the cycle where posX == 0 && posY == 0.
REQ-034 wr_cnt counts in-range transfers and saturates at 16'hFFFF.
REQ-035 On frame_tick: wr_count_last <= wr_cnt (including a transfer in that same cycle), and wr_cnt restarts at 0, or at 1 if a transfer occurs in that cycle.
REQ-036 posX/posY values outside the visible area (blanking) are never display slots; the arbiter tolerates any posX/posY sequence, including jumps.

Reset
REQ-037 On rst (synchronous, active-high), the following registers clear: pix_reg = 0, err_oob = 0, wr_cnt = 0, wr_count_last = 0.
REQ-038 On rst, last_grant = 1, so that w0 wins the first contention.
REQ-039 While rst is high: wN_ready = 0, mem_we = 0, frame_tick = 0.
REQ-040 rst asserted mid-transfer drops the pending request without a RAM write; the requester re-presents it after reset.

Verification
REQ-041 Scenario 1: posX = 8, posY = 4, mem_rdata = 3'b101 -> mem_addr = 162, mem_we = 0; the next cycle pix_reg = 3'b101 and pixel_to_vga = 3'b101.
REQ-042 Scenario 2: w0 and w1 valid continuously during blanking, starting after reset -> grants alternate w0, w1, w0, w1; each transfer writes its own addr/data.
REQ-043 Scenario 3: w0_valid held through posX = 0..7 of a visible line -> ready low at posX = 0 and 4; transfers occur at posX = 1, 2, 3, 5, 6, 7.
REQ-044 Scenario 4: w1 writes addr 19200 -> w1_ready = 1, mem_we = 0, err_oob = 1 and remains 1 after further writes; cleared only by rst.
REQ-045 Scenario 5: wr_vblank_only = 1 with w0_valid at posY = 100 (blanking column) -> no grant; at posY = 480 the write is granted.
REQ-046 Scenario 6: 5 in-range writes in a frame, then posX = 0 and posY = 0 -> frame_tick = 1 for one cycle, wr_count_last = 5, wr_cnt = 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port framebuffer RAM between the VGA scan-out and two
// write requesters. The VGA timing driver presents the position of the next
// pixel (posX/posY). Every fourth visible column is a display read slot. That
// slot owns the RAM and fetches the 4x4-upscaled framebuffer pixel. All other
// cycles are write slots, which are shared round-robin between w0 and w1. When
// wr_vblank_only is set, write slots exist only during vertical blanking.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   posX, posY                next pixel position from the VGA timing driver
//   pixel_to_vga              registered pixel toward the VGA driver
//   mem_addr/mem_we/mem_wdata framebuffer RAM control (1-cycle read latency)
//   mem_rdata                 framebuffer RAM read data
//   wN_valid/addr/data/ready  write requesters N = 0, 1 (valid/ready handshake)
//   wr_vblank_only            restrict writes to posY >= 480
//   frame_tick                one-cycle pulse at posX == 0 && posY == 0
//   err_oob                   sticky flag: a write addressed past the buffer
//   wr_count_last             in-range writes accepted during previous frame
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       posX,
    input  logic [10:0]       posY,
    output logic [PIX_W-1:0]  pixel_to_vga,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    input  logic              w0_valid,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [PIX_W-1:0]  w0_data,
    output logic              w0_ready,
    input  logic              w1_valid,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [PIX_W-1:0]  w1_data,
    output logic              w1_ready,
    input  logic              wr_vblank_only,
    output logic              frame_tick,
    output logic              err_oob,
    output logic [15:0]       wr_count_last
);

    localparam int FB_SIZE = FB_W * FB_H;

    // Requesters gathered into vectors so that the grant logic is indexed.
    logic [1:0]              w_valid;
    logic [1:0]              w_ready;
    logic [ADDR_W-1:0]       w_addr [2];
    logic [PIX_W-1:0]        w_data [2];

    assign w_valid   = {w1_valid, w0_valid};
    assign w_addr[0] = w0_addr;
    assign w_addr[1] = w1_addr;
    assign w_data[0] = w0_data;
    assign w_data[1] = w1_data;
    assign w0_ready  = w_ready[0];
    assign w1_ready  = w_ready[1];

    // Registers
    logic [PIX_W-1:0] pix_q,           pix_d;
    logic             disp_q,          disp_d;
    logic             last_grant_q,    last_grant_d;
    logic             err_oob_q,       err_oob_d;
    logic [15:0]      wr_cnt_q,        wr_cnt_d;
    logic [15:0]      wr_count_last_q, wr_count_last_d;

    // Slot classification
    logic        disp;
    logic        wslot;
    logic        sel;          // index of the requester granted in this slot
    logic        xfer;
    logic        xfer_in_range;
    logic [31:0] disp_addr_full;
    logic [15:0] wr_cnt_inc;

    // Visible area is 640x480; every fourth column fetches one framebuffer pixel.
    assign disp  = (posX < 11'd640) && (posY < 11'd480) && (posX[1:0] == 2'b00);
    assign wslot = !rst && !disp && (!wr_vblank_only || (posY >= 11'd480));

    // Full-width address math so that large parameters cannot wrap before
    // the result is narrowed to the RAM address width.
    assign disp_addr_full = 32'(posY >> 2) * 32'(FB_W) + 32'(posX >> 2);

    // Round-robin: on contention the requester that did not win last time goes.
    always_comb begin
        sel = 1'b0;
        if (w_valid == 2'b11) begin
            sel = ~last_grant_q;
        end else if (w_valid[1]) begin
            sel = 1'b1;
        end
    end

    assign xfer          = wslot && (w_valid != 2'b00);
    assign xfer_in_range = xfer && (32'(w_addr[sel]) < 32'(FB_SIZE));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign w_ready[gi] = wslot && w_valid[gi] && (sel == 1'(gi));
        end
    endgenerate

    // RAM port mux: display has priority, then an accepted in-range write.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (disp) begin
            mem_addr = disp_addr_full[ADDR_W-1:0];
        end else if (xfer) begin
            mem_addr  = w_addr[sel];
            mem_wdata = w_data[sel];
            mem_we    = xfer_in_range;
        end
    end

    assign frame_tick = !rst && (posX == 11'd0) && (posY == 11'd0);

    // Saturating count including any write accepted in this cycle.
    assign wr_cnt_inc = (xfer_in_range && (wr_cnt_q != 16'hFFFF)) ? wr_cnt_q + 16'd1
                                                                   : wr_cnt_q;

    always_comb begin
        disp_d          = disp;
        pix_d           = disp_q ? mem_rdata : pix_q;
        last_grant_d    = xfer ? sel : last_grant_q;
        err_oob_d       = err_oob_q || (xfer && !xfer_in_range);
        wr_cnt_d        = wr_cnt_inc;
        wr_count_last_d = wr_count_last_q;
        if (frame_tick) begin
            wr_count_last_d = wr_cnt_inc;
            wr_cnt_d        = {15'd0, xfer_in_range};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q           <= '0;
            disp_q          <= 1'b0;
            last_grant_q    <= 1'b1;
            err_oob_q       <= 1'b0;
            wr_cnt_q        <= 16'd0;
            wr_count_last_q <= 16'd0;
        end else begin
            pix_q           <= pix_d;
            disp_q          <= disp_d;
            last_grant_q    <= last_grant_d;
            err_oob_q       <= err_oob_d;
            wr_cnt_q        <= wr_cnt_d;
            wr_count_last_q <= wr_count_last_d;
        end
    end

    assign pixel_to_vga  = pix_q;
    assign err_oob       = err_oob_q;
    assign wr_count_last = wr_count_last_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Self-checking bench for vga_fb_arbiter. A table of single-cycle vectors
// checks the RAM mux and the round-robin grant. Each expected record is queued
// when its stimulus is driven and popped when the outputs are sampled. The
// multi-cycle behaviour is covered by hand-written sequences: pixel latency,
// display stealing, the sticky error, vblank gating, frame counting and reset.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] posX, posY;
    logic [2:0]  pixel_to_vga;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata, mem_rdata;
    logic        w0_valid, w1_valid, w0_ready, w1_ready;
    logic [14:0] w0_addr, w1_addr;
    logic [2:0]  w0_data, w1_data;
    logic        wr_vblank_only, frame_tick, err_oob;
    logic [15:0] wr_count_last;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .posX(posX), .posY(posY),
        .pixel_to_vga(pixel_to_vga),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .w0_valid(w0_valid), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ready(w0_ready),
        .w1_valid(w1_valid), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ready(w1_ready),
        .wr_vblank_only(wr_vblank_only), .frame_tick(frame_tick),
        .err_oob(err_oob), .wr_count_last(wr_count_last)
    );

    typedef struct {
        logic [10:0] px, py;
        logic        wvo;
        logic        v0;
        logic [14:0] a0;
        logic [2:0]  d0;
        logic        v1;
        logic [14:0] a1;
        logic [2:0]  d1;
        logic        e_we;
        logic [14:0] e_addr;
        logic [2:0]  e_wdata;
        logic        e_r0, e_r1;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        posX = 11'd700; posY = 11'd500;
        w0_valid = 1'b0; w0_addr = '0; w0_data = '0;
        w1_valid = 1'b0; w1_addr = '0; w1_data = '0;
        wr_vblank_only = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        vec_t e;
        // Grant sequence from reset (last_grant = 1, so w0 wins first contention).
        //            px      py     wvo  v0  a0       d0   v1  a1      d1    we  addr       wd    r0 r1
        vecs.push_back('{11'd700, 11'd500, 0, 1, 15'd10,  3'd1, 1, 15'd20, 3'd2, 1, 15'd10,    3'd1, 1, 0});
        vecs.push_back('{11'd700, 11'd500, 0, 1, 15'd10,  3'd1, 1, 15'd20, 3'd2, 1, 15'd20,    3'd2, 0, 1});
        vecs.push_back('{11'd701, 11'd500, 0, 1, 15'd11,  3'd3, 1, 15'd21, 3'd4, 1, 15'd11,    3'd3, 1, 0});
        vecs.push_back('{11'd702, 11'd500, 0, 1, 15'd11,  3'd3, 1, 15'd21, 3'd4, 1, 15'd21,    3'd4, 0, 1});
        vecs.push_back('{11'd703, 11'd500, 0, 0, 15'd0,   3'd0, 1, 15'd22, 3'd5, 1, 15'd22,    3'd5, 0, 1});
        vecs.push_back('{11'd704, 11'd500, 0, 0, 15'd0,   3'd0, 1, 15'd23, 3'd6, 1, 15'd23,    3'd6, 0, 1});
        vecs.push_back('{11'd705, 11'd500, 0, 1, 15'd12,  3'd7, 1, 15'd24, 3'd1, 1, 15'd12,    3'd7, 1, 0});
        vecs.push_back('{11'd706, 11'd500, 0, 0, 15'd0,   3'd0, 0, 15'd0,  3'd0, 0, 15'd0,     3'd0, 0, 0});
        vecs.push_back('{11'd8,   11'd4,   0, 1, 15'd100, 3'd2, 0, 15'd0,  3'd0, 0, 15'd162,   3'd0, 0, 0});
        vecs.push_back('{11'd9,   11'd4,   0, 1, 15'd100, 3'd2, 0, 15'd0,  3'd0, 1, 15'd100,   3'd2, 1, 0});
        vecs.push_back('{11'd700, 11'd100, 1, 1, 15'd101, 3'd1, 0, 15'd0,  3'd0, 0, 15'd0,     3'd0, 0, 0});
        vecs.push_back('{11'd0,   11'd480, 1, 1, 15'd101, 3'd1, 0, 15'd0,  3'd0, 1, 15'd101,   3'd1, 1, 0});
        vecs.push_back('{11'd636, 11'd476, 0, 0, 15'd0,   3'd0, 1, 15'd9,  3'd3, 0, 15'd19199, 3'd0, 0, 0});
        vecs.push_back('{11'd640, 11'd0,   0, 0, 15'd0,   3'd0, 1, 15'd5,  3'd7, 1, 15'd5,     3'd7, 0, 1});

        do_reset();

        // Reset state
        check("reset_pixel", 32'(pixel_to_vga), 32'd0);
        check("reset_err_oob", 32'(err_oob), 32'd0);
        check("reset_wr_count_last", 32'(wr_count_last), 32'd0);

        // Table-driven vectors through the scoreboard queue
        foreach (vecs[i]) begin
            posX = vecs[i].px; posY = vecs[i].py; wr_vblank_only = vecs[i].wvo;
            w0_valid = vecs[i].v0; w0_addr = vecs[i].a0; w0_data = vecs[i].d0;
            w1_valid = vecs[i].v1; w1_addr = vecs[i].a1; w1_data = vecs[i].d1;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            $display("vec %0d: posX=%0d posY=%0d we=%0b addr=%0d wdata=%0d r0=%0b r1=%0b",
                     i, posX, posY, mem_we, mem_addr, mem_wdata, w0_ready, w1_ready);
            check("vec_mem_we", 32'(mem_we), 32'(e.e_we));
            check("vec_mem_addr", 32'(mem_addr), 32'(e.e_addr));
            check("vec_mem_wdata", 32'(mem_wdata), 32'(e.e_wdata));
            check("vec_w0_ready", 32'(w0_ready), 32'(e.e_r0));
            check("vec_w1_ready", 32'(w1_ready), 32'(e.e_r1));
            step();
        end

        // Pixel fetch: slot at (8,4), data returned the following cycle.
        do_reset();
        posX = 11'd8; posY = 11'd4; mem_rdata = 3'b101;
        @(negedge clk);
        check("pix_slot_addr", 32'(mem_addr), 32'd162);
        check("pix_slot_we", 32'(mem_we), 32'd0);
        step();
        posX = 11'd9;
        @(negedge clk);
        check("pix_before_load", 32'(pixel_to_vga), 32'd0);
        step();
        mem_rdata = 3'b010;
        @(negedge clk);
        $display("pixel: pixel_to_vga=%0b", pixel_to_vga);
        check("pix_loaded", 32'(pixel_to_vga), 32'b101);
        step();
        @(negedge clk);
        check("pix_hold", 32'(pixel_to_vga), 32'b101);

        // Display slots steal posX = 0 and 4 from a continuous writer.
        do_reset();
        posY = 11'd10; w0_valid = 1'b1; w0_addr = 15'd50; w0_data = 3'd6;
        for (int x = 0; x < 8; x++) begin
            posX = 11'(x);
            @(negedge clk);
            $display("line: posX=%0d w0_ready=%0b mem_we=%0b", x, w0_ready, mem_we);
            check("steal_w0_ready", 32'(w0_ready), 32'((x % 4) != 0));
            check("steal_mem_we", 32'(mem_we), 32'((x % 4) != 0));
            step();
        end

        // Out-of-range write sets a sticky error.
        do_reset();
        w1_valid = 1'b1; w1_addr = 15'd19200; w1_data = 3'd3;
        @(negedge clk);
        check("oob_w1_ready", 32'(w1_ready), 32'd1);
        check("oob_mem_we", 32'(mem_we), 32'd0);
        check("oob_err_before", 32'(err_oob), 32'd0);
        step();
        w1_addr = 15'd7;
        @(negedge clk);
        check("oob_err_set", 32'(err_oob), 32'd1);
        check("inrange_after_oob_we", 32'(mem_we), 32'd1);
        step();
        w1_valid = 1'b0;
        @(negedge clk);
        $display("oob: err_oob=%0b", err_oob);
        check("oob_err_sticky", 32'(err_oob), 32'd1);
        do_reset();
        @(negedge clk);
        check("oob_err_cleared", 32'(err_oob), 32'd0);

        // Vblank-only gating
        step();
        wr_vblank_only = 1'b1; w0_valid = 1'b1; w0_addr = 15'd33; w0_data = 3'd5;
        posX = 11'd700; posY = 11'd100;
        @(negedge clk);
        check("vbl_blocked", 32'(w0_ready), 32'd0);
        step();
        posY = 11'd480;
        @(negedge clk);
        check("vbl_granted", 32'(w0_ready), 32'd1);
        check("vbl_we", 32'(mem_we), 32'd1);

        // Frame counting: 5 in-range writes plus one out-of-range one.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            w0_valid = 1'b1; w0_addr = (k == 5) ? 15'd20000 : 15'(k); w0_data = 3'(k);
            step();
        end
        w0_valid = 1'b0; posX = 11'd0; posY = 11'd0;
        @(negedge clk);
        check("frame_tick_high", 32'(frame_tick), 32'd1);
        step();
        posX = 11'd1;
        @(negedge clk);
        $display("frame: frame_tick=%0b wr_count_last=%0d", frame_tick, wr_count_last);
        check("frame_tick_low", 32'(frame_tick), 32'd0);
        check("wr_count_last_5", 32'(wr_count_last), 32'd5);
        step();
        posX = 11'd0;
        step();
        posX = 11'd1;
        @(negedge clk);
        check("wr_count_restart", 32'(wr_count_last), 32'd0);

        // Reset holds off grants, writes and frame_tick.
        step();
        rst = 1'b1; w0_valid = 1'b1; w0_addr = 15'd40; posX = 11'd700; posY = 11'd500;
        @(negedge clk);
        check("rst_w0_ready", 32'(w0_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        step();
        posX = 11'd0; posY = 11'd0;
        @(negedge clk);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);
        step();
        rst = 1'b0; posX = 11'd700; posY = 11'd500;
        @(negedge clk);
        check("post_rst_represent", 32'(w0_ready), 32'd1);
        check("post_rst_we", 32'(mem_we), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
